// File: rtl/dds_multi_nco.sv
// dds_multi_nco: multi-channel NCO sharing one waveform table, gain-scaled and saturated into one signed sample
module dds_multi_nco #(
  parameter int CHANNELS = 4,
  parameter int ACC_WIDTH = 24,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8,
  parameter int OUT_WIDTH = 16,
  parameter int STROBE_MAX = 520,
  localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en_i,
  input  logic                         wave_we_i,
  input  logic [ADDR_WIDTH-1:0]        wave_addr_i,
  input  logic [DATA_WIDTH-1:0]        wave_data_i,
  input  logic                         cfg_we_i,
  input  logic [CW-1:0]                cfg_ch_i,
  input  logic [1:0]                   cfg_sel_i,
  input  logic [ACC_WIDTH-1:0]         cfg_data_i,
  output logic signed [OUT_WIDTH-1:0]  sample_o,
  output logic                         sample_valid_o,
  output logic                         busy_o
);
  localparam int MW = DATA_WIDTH + 12;
  localparam int SW = MW + OUT_WIDTH;
  localparam int TW = $clog2(STROBE_MAX);
  localparam logic signed [SW-1:0] S_MAX = {{(SW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  typedef enum logic [1:0] {IDLE, ADDR, MAC, OUT} state_t;
  state_t state;
  logic [TW-1:0] cnt;
  logic [CW-1:0] ch;
  logic [ACC_WIDTH-1:0] acc [CHANNELS];
  logic [ACC_WIDTH-1:0] tw_s [CHANNELS];
  logic [ACC_WIDTH-1:0] off_s [CHANNELS];
  logic [ACC_WIDTH-1:0] tw_a [CHANNELS];
  logic [ACC_WIDTH-1:0] off_a [CHANNELS];
  logic [10:0] cfg_s [CHANNELS];
  logic [10:0] cfg_a [CHANNELS];
  logic [CHANNELS-1:0] sync_s;
  logic signed [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic signed [DATA_WIDTH-1:0] rd, w_gen, w_nxt, w;
  logic [DATA_WIDTH-1:0] tri_t;
  logic [ADDR_WIDTH-1:0] p;
  logic [1:0] mode;
  logic signed [MW-1:0] mix, mix_n, prod;
  logic signed [SW-1:0] s_full;
  logic signed [OUT_WIDTH-1:0] sat;
  logic strobe, cfg_ok, last;

  always_comb begin
    strobe = en_i && cnt == TW'(STROBE_MAX - 1);
    cfg_ok = 32'(cfg_ch_i) < CHANNELS;
    last = 32'(ch) == CHANNELS - 1;
    mode = cfg_a[ch][9:8];
    p = ADDR_WIDTH'((acc[ch] + off_a[ch]) >> (ACC_WIDTH - ADDR_WIDTH));
    tri_t = p[ADDR_WIDTH-2 -: DATA_WIDTH] ^ {DATA_WIDTH{p[ADDR_WIDTH-1]}};
    w_nxt = mode == 2'd1 ? (p[ADDR_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}}) :
            mode == 2'd2 ? {~p[ADDR_WIDTH-1], p[ADDR_WIDTH-2 -: DATA_WIDTH-1]} :
            {~tri_t[DATA_WIDTH-1], tri_t[DATA_WIDTH-2:0]};
    w = mode == 2'd0 ? rd : w_gen;
    prod = MW'(w * $signed({1'b0, cfg_a[ch][7:0]}));
    mix_n = cfg_a[ch][10] ? mix + prod : mix;
    s_full = (SW'(mix_n) >>> 8) <<< (OUT_WIDTH - DATA_WIDTH);
    sat = s_full > S_MAX ? {1'b0, {(OUT_WIDTH-1){1'b1}}} :
          s_full < ~S_MAX ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : s_full[OUT_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (wave_we_i) mem[wave_addr_i] <= wave_data_i;
    rd <= mem[p];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      ch <= '0;
      mix <= '0;
      w_gen <= '0;
      sample_o <= '0;
      sample_valid_o <= 1'b0;
      busy_o <= 1'b0;
      sync_s <= '0;
      acc <= '{default: '0};
      tw_s <= '{default: '0};
      off_s <= '{default: '0};
      cfg_s <= '{default: '0};
      tw_a <= '{default: '0};
      off_a <= '{default: '0};
      cfg_a <= '{default: '0};
    end else begin
      cnt <= !en_i || strobe ? '0 : cnt + 1'b1;
      if (cfg_we_i && cfg_ok && cfg_sel_i == 2'd0) tw_s[cfg_ch_i] <= cfg_data_i;
      if (cfg_we_i && cfg_ok && cfg_sel_i == 2'd1) off_s[cfg_ch_i] <= cfg_data_i;
      if (cfg_we_i && cfg_ok && cfg_sel_i == 2'd2) cfg_s[cfg_ch_i] <= cfg_data_i[10:0];
      sync_s <= cfg_we_i && cfg_sel_i == 2'd3 ? cfg_data_i[CHANNELS-1:0] :
                state == IDLE && strobe ? '0 : sync_s;
      case (state)
        IDLE: if (strobe) begin
          tw_a <= tw_s;
          off_a <= off_s;
          cfg_a <= cfg_s;
          for (int i = 0; i < CHANNELS; i++) acc[i] <= sync_s[i] ? '0 : acc[i];
          mix <= '0;
          ch <= '0;
          busy_o <= 1'b1;
          state <= ADDR;
        end
        ADDR: begin
          acc[ch] <= cfg_a[ch][10] ? acc[ch] + tw_a[ch] : '0;
          w_gen <= w_nxt;
          state <= MAC;
        end
        MAC: begin
          mix <= mix_n;
          ch <= last ? ch : ch + 1'b1;
          sample_o <= last ? sat : sample_o;
          sample_valid_o <= last;
          state <= last ? OUT : ADDR;
        end
        OUT: begin
          sample_valid_o <= 1'b0;
          busy_o <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dds_multi_nco.sv
// tb_dds_multi_nco: randomized self-checking bench against a behavioural oscillator/mixer model
module tb_dds_multi_nco;
  localparam int CH = 4;
  localparam int ACC = 24;
  localparam int AW = 10;
  localparam int DW = 8;
  localparam int OW = 16;
  localparam int SMAX = 520;
  localparam int unsigned MASK = (1 << ACC) - 1;
  localparam int MAXV = (1 << (OW - 1)) - 1;
  localparam int MINV = -(1 << (OW - 1));

  logic clk = 1'b0, rst_n = 1'b0, en_i = 1'b0, wave_we_i = 1'b0, cfg_we_i = 1'b0;
  logic [AW-1:0] wave_addr_i = '0;
  logic [DW-1:0] wave_data_i = '0;
  logic [1:0] cfg_ch_i = '0, cfg_sel_i = '0;
  logic [ACC-1:0] cfg_data_i = '0;
  logic signed [OW-1:0] sample_o;
  logic sample_valid_o, busy_o;
  int n_vec = 0, n_bad = 0;

  dds_multi_nco dut (
    .clk(clk), .rst_n(rst_n), .en_i(en_i),
    .wave_we_i(wave_we_i), .wave_addr_i(wave_addr_i), .wave_data_i(wave_data_i),
    .cfg_we_i(cfg_we_i), .cfg_ch_i(cfg_ch_i), .cfg_sel_i(cfg_sel_i), .cfg_data_i(cfg_data_i),
    .sample_o(sample_o), .sample_valid_o(sample_valid_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  int unsigned acc_m [CH], tw_s [CH], off_s [CH], tw_a [CH], off_a [CH];
  logic [10:0] cfg_s [CH], cfg_a [CH];
  logic [CH-1:0] pend_m;
  int p_m [CH], tv_m [CH];
  int mem_m [1 << AW];
  int cnt_m, k_m, exp_sample;
  bit scan_m, exp_valid, stb_m;

  function automatic int wave(input int m, input int p, input int tv);
    int msb = (p >> (AW - 1)) & 1;
    int t = (p >> (AW - 1 - DW)) & ((1 << DW) - 1);
    if (m == 0) return tv;
    if (m == 1) return msb ? -(1 << (DW - 1)) : (1 << (DW - 1)) - 1;
    if (m == 2) return (p >> (AW - DW)) - (1 << (DW - 1));
    return (msb ? ((1 << DW) - 1 - t) : t) - (1 << (DW - 1));
  endfunction

  function automatic int mix_m();
    int s = 0;
    for (int i = 0; i < CH; i++)
      if (cfg_a[i][10]) s += wave(int'(cfg_a[i][9:8]), p_m[i], tv_m[i]) * int'(cfg_a[i][7:0]);
    s = (s >>> 8) * (1 << (OW - DW));
    return s > MAXV ? MAXV : s < MINV ? MINV : s;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_m = 0; k_m = 0; scan_m = 0; exp_valid = 0; exp_sample = 0; pend_m = '0;
      for (int i = 0; i < CH; i++) begin
        acc_m[i] = 0; tw_s[i] = 0; off_s[i] = 0; tw_a[i] = 0; off_a[i] = 0; cfg_s[i] = '0; cfg_a[i] = '0;
      end
    end else begin
      stb_m = en_i && cnt_m == SMAX - 1;
      cnt_m = en_i ? (cnt_m + 1) % SMAX : 0;
      if (scan_m) begin
        k_m++;
        for (int i = 0; i < CH; i++) if (k_m == 2 * i + 1) tv_m[i] = mem_m[p_m[i]];
        if (k_m == 2 * CH) begin
          exp_sample = mix_m();
          exp_valid = 1;
        end else if (k_m == 2 * CH + 1) begin
          exp_valid = 0;
          scan_m = 0;
        end
      end else if (stb_m) begin
        for (int i = 0; i < CH; i++) begin
          tw_a[i] = tw_s[i]; off_a[i] = off_s[i]; cfg_a[i] = cfg_s[i];
          if (pend_m[i]) acc_m[i] = 0;
          p_m[i] = int'(((acc_m[i] + off_a[i]) & MASK) >> (ACC - AW));
          acc_m[i] = cfg_a[i][10] ? (acc_m[i] + tw_a[i]) & MASK : 0;
        end
        pend_m = '0;
        scan_m = 1;
        k_m = 0;
      end
      if (cfg_we_i && cfg_sel_i == 2'd3) pend_m = cfg_data_i[CH-1:0];
      else if (cfg_we_i && cfg_sel_i == 2'd0) tw_s[cfg_ch_i] = cfg_data_i;
      else if (cfg_we_i && cfg_sel_i == 2'd1) off_s[cfg_ch_i] = cfg_data_i;
      else if (cfg_we_i) cfg_s[cfg_ch_i] = cfg_data_i[10:0];
      if (wave_we_i) mem_m[wave_addr_i] = $signed(wave_data_i);
    end
  end

  always @(negedge clk) if (rst_n) begin
    chk("valid", sample_valid_o, exp_valid);
    chk("busy", busy_o, scan_m);
    chk("sample", sample_o, exp_sample);
  end

  task automatic cfg(input int c, input int s, input int unsigned d);
    @(negedge clk);
    cfg_we_i = 1'b1; cfg_ch_i = 2'(c); cfg_sel_i = 2'(s); cfg_data_i = ACC'(d);
    @(negedge clk);
    cfg_we_i = 1'b0;
  endtask

  task automatic wave_wr(input int a, input int d);
    @(negedge clk);
    wave_we_i = 1'b1; wave_addr_i = AW'(a); wave_data_i = DW'(d);
    @(negedge clk);
    wave_we_i = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sample_valid_o && n < 1200);
    chk("valid_wait", sample_valid_o, 1);
  endtask

  task automatic wait_busy_rise();
    int n = 0;
    while (busy_o && n < 2000) begin @(negedge clk); n++; end
    while (!busy_o && n < 2000) begin @(negedge clk); n++; end
    chk("busy_wait", busy_o, 1);
  endtask

  int n, a, e, old, addr;

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_sample", sample_o, 0);
    chk("rst_valid", sample_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    for (int i = 0; i < (1 << AW); i++) wave_wr(i, (i >> 2) - 128);
    cfg(0, 0, 1 << 23);
    cfg(0, 2, 1024 + 256 + 128);
    en_i = 1'b1;
    wait_valid(n);
    chk("first_latency", n, SMAX + 2 * CH);
    chk("square_hi", sample_o, 16128);
    wait_valid(n);
    chk("period", n, SMAX);
    chk("square_lo", sample_o, -16384);
    for (int c = 0; c < CH; c++) begin
      cfg(c, 0, 0);
      cfg(c, 1, 0);
      cfg(c, 2, 1024 + 256 + 255);
    end
    cfg(0, 3, 15);
    wait_valid(n);
    chk("sat_pos", sample_o, MAXV);
    for (int c = 0; c < CH; c++) cfg(c, 1, 1 << 23);
    wait_valid(n);
    chk("sat_neg", sample_o, MINV);
    cfg(0, 2, 1024 + 255);
    cfg(0, 0, 1 << 14);
    cfg(0, 1, 1020 << 14);
    for (int c = 1; c < CH; c++) cfg(c, 2, 0);
    cfg(0, 3, 1);
    for (int i = 0; i < 6; i++) begin
      wait_valid(n);
      a = (1020 + i) % 1024;
      e = ((((a >> 2) - 128) * 255) >>> 8) * 256;
      chk("table_ramp", sample_o, e);
    end
    wait_busy_rise();
    cfg(0, 0, 1 << 15);
    wait_valid(n);
    chk("shadow_cur", sample_o, -32768);
    cfg(0, 3, 1);
    for (int i = 0; i < 3; i++) begin
      wait_valid(n);
      a = (1020 + 2 * i) % 1024;
      e = ((((a >> 2) - 128) * 255) >>> 8) * 256;
      chk("sync_restart", sample_o, e);
    end
    wait_busy_rise();
    addr = p_m[0];
    old = mem_m[addr];
    wave_we_i = 1'b1; wave_addr_i = AW'(addr); wave_data_i = DW'(~old);
    @(negedge clk);
    wave_we_i = 1'b0;
    wait_valid(n);
    chk("rdw_old", sample_o, ((old * 255) >>> 8) * 256);
    cfg(1, 0, 1 << 20);
    cfg(1, 2, 1024 + 256 + 200);
    wait_valid(n);
    wait_valid(n);
    cfg(1, 2, 0);
    wait_valid(n);
    for (int it = 0; it < 25; it++) begin
      repeat ($urandom_range(0, 4)) begin
        int s = $urandom_range(0, 3);
        cfg($urandom_range(0, CH - 1), s,
            s == 2 ? $urandom_range(0, 2047) : s == 3 ? $urandom_range(0, 15) : $urandom & MASK);
      end
      if ($urandom_range(0, 3) == 0) wave_wr($urandom_range(0, (1 << AW) - 1), $urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) begin
        en_i = 1'b0;
        repeat ($urandom_range(1, 20)) @(negedge clk);
        en_i = 1'b1;
      end
      repeat ($urandom_range(50, 700)) @(negedge clk);
    end
    wait_busy_rise();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_sample", sample_o, 0);
    chk("async_rst_valid", sample_valid_o, 0);
    chk("async_rst_busy", busy_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_valid(n);
    chk("post_rst_latency", n, SMAX + 2 * CH);
    chk("post_rst_sample", sample_o, 0);
    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
    $fatal(1);
  end
endmodule
